// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the program counter, issues at most one
//   outstanding word read on the instruction bus, and presents the fetched
//   {instr, pc} pair to decode over a valid/ready handshake. Decode may
//   redirect the PC at any time. A redirect squashes any wrong-path fetch
//   that is still in flight on the bus.
//
// Parameters
//   RESET_PC        PC loaded on reset
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   ireq_valid      bus read request valid
//   ireq_addr       bus read address, word aligned copy of the PC
//   ireq_addr_ok    bus accepted the request this cycle
//   iresp_data_ok   bus returns read data this cycle
//   iresp_data      read data
//   out_valid       {out_instr, out_pc, out_adel} valid to decode
//   out_ready       decode accepts this cycle
//   out_instr       fetched instruction, zero on an address error
//   out_pc          PC of out_instr
//   out_adel        PC misaligned, instruction-fetch address error
//   redirect_valid  decode requests a PC change this cycle
//   redirect_pc     new PC
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_adel,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  // S_REQ  : presenting a read request (or detecting a misaligned PC)
  // S_WAIT : request accepted, waiting for the bus to return data
  // S_OUT  : holding a fetched instruction until decode takes it
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        kill;
  logic        kill_next;
  logic [31:0] instr_q;
  logic [31:0] instr_next;
  logic [31:0] pc_q;
  logic [31:0] opc_next;
  logic        adel_q;
  logic        adel_next;

  logic        pc_aligned;
  logic        req_accept;
  logic        handshake;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // A misaligned PC never goes out on the bus, so an addr_ok seen while the
  // request is suppressed must not count as an accepted request.
  assign req_accept = (state == S_REQ) && pc_aligned && ireq_addr_ok;

  // Bus and decode outputs are forced low while reset is held so nothing
  // leaks out during the reset cycle, whatever the registers contained.
  assign ireq_valid = !reset && (state == S_REQ) && pc_aligned;
  assign ireq_addr  = {pc[31:2], 2'b00};
  assign out_valid  = !reset && (state == S_OUT);
  assign out_instr  = instr_q;
  assign out_pc     = pc_q;
  assign out_adel   = adel_q;

  assign handshake  = (state == S_OUT) && out_ready;

  // Next-state and datapath update. A redirect always wins over the
  // sequential pc+4 step. The kill flag remembers that the single request
  // in flight belongs to a squashed path, so its response is discarded
  // when it eventually arrives.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    instr_next = instr_q;
    opc_next   = pc_q;
    adel_next  = adel_q;

    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          // The old address was taken by the bus in this very cycle, so a
          // response is still coming and must be thrown away.
          if (req_accept) begin
            state_next = S_WAIT;
            kill_next  = 1'b1;
          end
        end else if (!pc_aligned) begin
          state_next = S_OUT;
          adel_next  = 1'b1;
          instr_next = 32'h0;
          opc_next   = pc;
        end else if (req_accept) begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end
        if (iresp_data_ok) begin
          if (kill || redirect_valid) begin
            state_next = S_REQ;
            kill_next  = 1'b0;
          end else begin
            state_next = S_OUT;
            instr_next = iresp_data;
            opc_next   = pc;
            adel_next  = 1'b0;
          end
        end else if (redirect_valid) begin
          kill_next = 1'b1;
        end
      end

      S_OUT: begin
        // The held instruction is simply abandoned on a redirect; since
        // out_valid drops with the state change, the stale payload in the
        // output registers is never seen by decode.
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = S_REQ;
        end else if (handshake) begin
          pc_next    = pc + 32'd4;
          state_next = S_REQ;
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // State register and datapath registers. Reset wins over everything,
  // including a redirect or a bus response in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      adel_q  <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      kill    <= kill_next;
      instr_q <= instr_next;
      pc_q    <= opc_next;
      adel_q  <= adel_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. Directed scenarios walk through the
//   reset, stall, redirect, misaligned-PC and wrap-around cases; a random
//   traffic phase then drives a randomly timed bus and random decode
//   back-pressure and redirects against a PC-stream model: every instruction
//   handed to decode must be the memory word at the PC the program would
//   reach by sequential +4 steps and redirects.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_adel;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests;
  int fails;

  fetch_unit #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .ireq_addr_ok   (ireq_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_adel       (out_adel),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Inputs are driven and outputs sampled just after the falling edge, well
  // away from the rising edge the DUT acts on.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ireq_addr_ok   = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    tests++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_valids: ireq_valid=%b out_valid=%b, want 0 0", ireq_valid, out_valid);
    end
    tests++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_adel !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outs: instr=%h pc=%h adel=%b, want 0 0 0", out_instr, out_pc, out_adel);
    end
    reset = 1'b0;
    step();
    tests++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc0_0000) begin
      fails++;
      $display("[TB] FAIL first_req: valid=%b addr=%h, want 1 bfc00000", ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_basic_fetch();
    ireq_addr_ok = 1'b1;
    step();
    ireq_addr_ok = 1'b0;
    tests++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wait_idle: ireq_valid=%b out_valid=%b, want 0 0", ireq_valid, out_valid);
    end
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hd000_0000;
    step();
    iresp_data_ok = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'hd000_0000 || out_pc !== 32'hbfc0_0000 || out_adel !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_out: valid=%b instr=%h pc=%h adel=%b, want 1 d0000000 bfc00000 0",
               out_valid, out_instr, out_pc, out_adel);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc0_0004 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_next: valid=%b addr=%h out_valid=%b, want 1 bfc00004 0",
               ireq_valid, ireq_addr, out_valid);
    end
  endtask

  task automatic test_stall();
    ireq_addr_ok = 1'b1;
    step();
    ireq_addr_ok  = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = mem_word(32'hbfc0_0004);
    step();
    iresp_data_ok = 1'b0;
    iresp_data    = 32'hffff_ffff;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_instr !== mem_word(32'hbfc0_0004) ||
          out_pc !== 32'hbfc0_0004 || ireq_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h ireq=%b, want 1 %h bfc00004 0",
                 i, out_valid, out_instr, out_pc, ireq_valid, mem_word(32'hbfc0_0004));
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc0_0008 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_release: valid=%b addr=%h out_valid=%b, want 1 bfc00008 0",
               ireq_valid, ireq_addr, out_valid);
    end
  endtask

  task automatic test_redirect_wait();
    ireq_addr_ok = 1'b1;
    step();
    ireq_addr_ok   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL redir_wait_idle[%0d]: out_valid=%b ireq=%b, want 0 0", i, out_valid, ireq_valid);
      end
      step();
    end
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hdead_beef;
    step();
    iresp_data_ok = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_1000) begin
      fails++;
      $display("[TB] FAIL redir_wait_drop: out_valid=%b ireq=%b addr=%h, want 0 1 80001000",
               out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_redirect_accept();
    ireq_addr_ok   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    step();
    ireq_addr_ok   = 1'b0;
    redirect_valid = 1'b0;
    tests++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL redir_acc_wait: ireq=%b out_valid=%b, want 0 0", ireq_valid, out_valid);
    end
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hbad0_bad0;
    step();
    iresp_data_ok = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_2000) begin
      fails++;
      $display("[TB] FAIL redir_acc_drop: out_valid=%b ireq=%b addr=%h, want 0 1 80002000",
               out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0002;
    step();
    redirect_valid = 1'b0;
    tests++;
    if (ireq_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL adel_noreq: ireq=%b, want 0", ireq_valid);
    end
    ireq_addr_ok = 1'b1;
    step();
    ireq_addr_ok = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_adel !== 1'b1 || out_instr !== 32'h0 ||
        out_pc !== 32'h8000_0002 || ireq_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL adel_out: valid=%b adel=%b instr=%h pc=%h ireq=%b, want 1 1 0 80000002 0",
               out_valid, out_adel, out_instr, out_pc, ireq_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    step();
    redirect_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'hffff_fffc) begin
      fails++;
      $display("[TB] FAIL adel_redirect: out_valid=%b ireq=%b addr=%h, want 0 1 fffffffc",
               out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    ireq_addr_ok = 1'b1;
    step();
    ireq_addr_ok  = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = mem_word(32'hffff_fffc);
    step();
    iresp_data_ok = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'hffff_fffc || out_instr !== mem_word(32'hffff_fffc)) begin
      fails++;
      $display("[TB] FAIL wrap_out: valid=%b pc=%h instr=%h, want 1 fffffffc %h",
               out_valid, out_pc, out_instr, mem_word(32'hffff_fffc));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'h0000_0000) begin
      fails++;
      $display("[TB] FAIL wrap_addr: ireq=%b addr=%h, want 1 00000000", ireq_valid, ireq_addr);
    end
    ireq_addr_ok = 1'b1;
    step();
    ireq_addr_ok = 1'b0;
    reset        = 1'b1;
    step();
    tests++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_hold: ireq=%b out_valid=%b, want 0 0", ireq_valid, out_valid);
    end
    reset = 1'b0;
    step();
    tests++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc0_0000 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_restart: ireq=%b addr=%h out_valid=%b, want 1 bfc00000 0",
               ireq_valid, ireq_addr, out_valid);
    end
  endtask

  // Random traffic. The model only tracks the architectural PC stream: a
  // handshake advances it by 4, a redirect replaces it. The bus model keeps
  // one outstanding read and answers 1..3 cycles after accepting it.
  task automatic test_random_traffic();
    logic [31:0] model_pc;
    logic [31:0] exp_instr;
    logic        exp_adel;
    logic        bus_busy;
    logic [31:0] bus_addr;
    int          bus_delay;
    int          handshakes;
    model_pc   = 32'hbfc0_0000;
    bus_busy   = 1'b0;
    bus_addr   = 32'h0;
    bus_delay  = 0;
    handshakes = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_inputs();

      if (ireq_valid) begin
        tests++;
        if (bus_busy || ireq_addr !== {model_pc[31:2], 2'b00} || model_pc[1:0] != 2'b00) begin
          fails++;
          $display("[TB] FAIL rand_req cyc %0d: addr=%h busy=%b, want %h with aligned pc %h and idle bus",
                   cyc, ireq_addr, bus_busy, {model_pc[31:2], 2'b00}, model_pc);
        end
      end

      if (out_valid) begin
        exp_adel  = (model_pc[1:0] != 2'b00);
        exp_instr = exp_adel ? 32'h0 : mem_word(model_pc);
        tests++;
        if (out_pc !== model_pc || out_instr !== exp_instr || out_adel !== exp_adel) begin
          fails++;
          $display("[TB] FAIL rand_out cyc %0d: pc=%h instr=%h adel=%b, want %h %h %b",
                   cyc, out_pc, out_instr, out_adel, model_pc, exp_instr, exp_adel);
        end
      end

      if (bus_busy) begin
        bus_delay--;
        if (bus_delay == 0) begin
          iresp_data_ok = 1'b1;
          iresp_data    = mem_word(bus_addr);
          bus_busy      = 1'b0;
        end
      end
      if (!bus_busy && ireq_valid && ($urandom_range(0, 1) == 1)) begin
        ireq_addr_ok = 1'b1;
        bus_busy     = 1'b1;
        bus_addr     = ireq_addr;
        bus_delay    = $urandom_range(1, 3);
      end

      if ($urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 7))
          0:       redirect_pc = $urandom | 32'h1;
          1:       redirect_pc = 32'hffff_fff8;
          default: redirect_pc = $urandom & 32'hffff_fffc;
        endcase
        model_pc = redirect_pc;
      end else if ($urandom_range(0, 3) != 0) begin
        out_ready = 1'b1;
        if (out_valid) begin
          model_pc = model_pc + 32'd4;
          handshakes++;
        end
      end

      step();
    end
    clear_inputs();
    tests++;
    if (handshakes < 40) begin
      fails++;
      $display("[TB] FAIL rand_progress: %0d handshakes, want at least 40", handshakes);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    clear_inputs();
    step();
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_accept();
    test_misaligned();
    test_wrap_and_reset();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
